// File: rtl/capture_bank.sv
// Bank of independent per-channel capture registers with a valid/ack handshake,
// sticky overrun flags and a shared count of accepted loads.
module capture_bank #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int MODE     = 1,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       ack,
   input  logic                      clr_ovr,
   output logic [CHANNELS*WIDTH-1:0] dout,
   output logic [CHANNELS-1:0]       valid,
   output logic [CHANNELS-1:0]       overrun,
   output logic [CNT_W-1:0]          cap_count
);

   localparam int SUM_W = $clog2(CHANNELS + 1);
   localparam int ADD_W = (CNT_W > SUM_W) ? CNT_W : SUM_W;

   typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

   state_t                    r_state     [CHANNELS];
   state_t                    w_state_nxt [CHANNELS];
   logic [CHANNELS-1:0]       w_load;
   logic [CHANNELS-1:0]       w_ovr_set;
   logic [CHANNELS-1:0]       r_ovr;
   logic [CHANNELS*WIDTH-1:0] r_dout;
   logic [CNT_W-1:0]          r_cnt;
   logic [SUM_W-1:0]          w_sum;
   logic [ADD_W-1:0]          w_cnt_add;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dout <= '0;
         r_ovr  <= '0;
         r_cnt  <= '0;
         for (int i = 0; i < CHANNELS; i++) r_state[i] <= S_IDLE;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_state[i] <= w_state_nxt[i];
            if (w_load[i]) r_dout[i*WIDTH +: WIDTH] <= din[i*WIDTH +: WIDTH];
         end
         // A new overrun event beats a simultaneous clear
         r_ovr <= w_ovr_set | (r_ovr & ~{CHANNELS{clr_ovr}});
         r_cnt <= w_cnt_add[CNT_W-1:0];
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_load[i]      = 1'b0;
         w_ovr_set[i]   = 1'b0;
         if (MODE == 1) begin
            case (r_state[i])
               S_IDLE: begin
                  if (en[i]) begin
                     w_load[i]      = 1'b1;
                     w_state_nxt[i] = S_HELD;
                  end
               end
               S_HELD: begin
                  if (en[i] && ack[i]) begin
                     w_load[i] = 1'b1;
                  end else if (ack[i]) begin
                     w_state_nxt[i] = S_IDLE;
                  end else if (en[i]) begin
                     w_ovr_set[i] = 1'b1;
                  end
               end
               default: w_state_nxt[i] = S_IDLE;
            endcase
         end else begin
            if (en[i]) begin
               w_load[i]      = 1'b1;
               w_state_nxt[i] = S_HELD;
            end else if (ack[i]) begin
               w_state_nxt[i] = S_IDLE;
            end
         end
         w_sum = w_sum + SUM_W'(w_load[i]);
      end
      // Widen both operands so a full-bank load never truncates before the wrap
      w_cnt_add = ADD_W'(r_cnt) + ADD_W'(w_sum);
   end

   always_comb begin
      valid = '0;
      for (int i = 0; i < CHANNELS; i++) valid[i] = (r_state[i] == S_HELD);
   end

   assign dout      = r_dout;
   assign overrun   = r_ovr;
   assign cap_count = r_cnt;

endmodule

// File: tb/tb_capture_bank.sv
// Directed bench for capture_bank: a CAPTURE bank with a 4-bit counter and a FOLLOW bank.
module tb_capture_bank;

   logic        clk;
   logic        reset;
   logic        clr_ovr;

   logic [31:0] c_din;
   logic [3:0]  c_en, c_ack;
   logic [31:0] c_dout;
   logic [3:0]  c_valid, c_ovr;
   logic [3:0]  c_cnt;

   logic [31:0] f_din;
   logic [3:0]  f_en, f_ack;
   logic [31:0] f_dout;
   logic [3:0]  f_valid, f_ovr;
   logic [15:0] f_cnt;

   int n_vec;
   int n_miss;

   capture_bank #(.WIDTH(8), .CHANNELS(4), .MODE(1), .CNT_W(4)) u_cap (
      .clk(clk), .reset(reset), .din(c_din), .en(c_en), .ack(c_ack),
      .clr_ovr(clr_ovr), .dout(c_dout), .valid(c_valid), .overrun(c_ovr),
      .cap_count(c_cnt)
   );

   capture_bank #(.WIDTH(8), .CHANNELS(4), .MODE(0), .CNT_W(16)) u_fol (
      .clk(clk), .reset(reset), .din(f_din), .en(f_en), .ack(f_ack),
      .clr_ovr(clr_ovr), .dout(f_dout), .valid(f_valid), .overrun(f_ovr),
      .cap_count(f_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0; n_miss = 0;
      reset = 1'b1; clr_ovr = 1'b0;
      c_din = '0; c_en = '0; c_ack = '0;
      f_din = '0; f_en = '0; f_ack = '0;
      tick();
      tick();
      reset = 1'b0;
      check_vec("por_dout",  c_dout,  32'h0);
      check_vec("por_valid", c_valid, 4'h0);
      check_vec("por_cnt",   c_cnt,   4'h0);

      // all channels held with A5, then an overrun on each
      c_en = 4'hF; c_din = 32'hA5A5A5A5;
      tick();
      check_vec("held_dout",  c_dout,  32'hA5A5A5A5);
      check_vec("held_valid", c_valid, 4'hF);
      check_vec("held_cnt",   c_cnt,   4'd4);
      tick();
      check_vec("held_ovr",   c_ovr,   4'hF);
      check_vec("held_cnt2",  c_cnt,   4'd4);
      c_en = '0;

      // asynchronous reset mid-clock
      #4;
      reset = 1'b1;
      #1;
      check_vec("arst_dout",  c_dout,  32'h0);
      check_vec("arst_valid", c_valid, 4'h0);
      check_vec("arst_ovr",   c_ovr,   4'h0);
      check_vec("arst_cnt",   c_cnt,   4'h0);
      repeat (3) tick();
      check_vec("rst3_dout",  c_dout,  32'h0);
      check_vec("rst3_valid", c_valid, 4'h0);
      check_vec("rst3_cnt",   c_cnt,   4'h0);
      reset = 1'b0;

      // capture basic on ch0
      c_en = 4'b0001; c_din = 32'h0000003C;
      tick();
      check_vec("cap_dout0",  c_dout[7:0], 8'h3C);
      check_vec("cap_valid",  c_valid,     4'b0001);
      check_vec("cap_cnt",    c_cnt,       4'd1);
      c_en = '0; c_din = 32'h000000FF;
      tick();
      check_vec("hold_dout0", c_dout[7:0], 8'h3C);
      check_vec("hold_valid", c_valid,     4'b0001);
      c_ack = 4'b0001;
      tick();
      check_vec("ack_valid",  c_valid,     4'b0000);
      check_vec("ack_dout0",  c_dout[7:0], 8'h3C);
      c_ack = '0;

      // overrun on ch1
      c_en = 4'b0010; c_din = 32'h00001100;
      tick();
      check_vec("ov_load1",   c_dout[15:8], 8'h11);
      check_vec("ov_cnt0",    c_cnt,        4'd2);
      c_din = 32'h00002200;
      tick();
      check_vec("ov_dout1",   c_dout[15:8], 8'h11);
      check_vec("ov_flag",    c_ovr,        4'b0010);
      check_vec("ov_cnt1",    c_cnt,        4'd2);
      clr_ovr = 1'b1; c_din = 32'h00003300;
      tick();
      check_vec("ov_setwins", c_ovr,        4'b0010);
      check_vec("ov_dout1b",  c_dout[15:8], 8'h11);
      c_en = '0;
      tick();
      check_vec("ov_clr",     c_ovr,        4'b0000);
      clr_ovr = 1'b0;

      // ack and en together on a held ch2
      c_en = 4'b0100; c_din = 32'h00050000;
      tick();
      check_vec("ae_load",    c_dout[23:16], 8'h05);
      check_vec("ae_cnt0",    c_cnt,         4'd3);
      c_ack = 4'b0100; c_din = 32'h00060000;
      tick();
      check_vec("ae_dout2",   c_dout[23:16], 8'h06);
      check_vec("ae_valid",   c_valid,       4'b0110);
      check_vec("ae_ovr",     c_ovr,         4'b0000);
      check_vec("ae_cnt1",    c_cnt,         4'd4);
      c_en = '0;
      c_ack = 4'b1000;
      tick();
      check_vec("idle_ack",   c_valid,       4'b0110);
      check_vec("idle_cnt",   c_cnt,         4'd4);
      check_vec("indep_d0",   c_dout[7:0],   8'h3C);

      // drive the counter to 14 with all channels idle, then load all four
      c_ack = 4'hF;
      tick();
      check_vec("all_idle",   c_valid,       4'h0);
      c_en = 4'b0001; c_ack = 4'b0001; c_din = 32'h00000077;
      repeat (10) tick();
      c_en = '0; c_ack = 4'hF;
      tick();
      check_vec("pre_cnt",    c_cnt,         4'd14);
      check_vec("pre_valid",  c_valid,       4'h0);
      c_ack = '0; c_en = 4'hF; c_din = 32'h44332211;
      tick();
      check_vec("wrap_cnt",   c_cnt,         4'd2);
      check_vec("wrap_dout",  c_dout,        32'h44332211);
      check_vec("wrap_valid", c_valid,       4'hF);
      c_en = '0;

      // follow mode on ch0
      check_vec("f_cnt0",     f_cnt,         16'd0);
      f_en = 4'b0001; f_din = 32'd1;
      tick();
      check_vec("f_d1",       f_dout,        32'd1);
      f_din = 32'd2;
      tick();
      check_vec("f_d2",       f_dout,        32'd2);
      f_din = 32'd3;
      tick();
      check_vec("f_d3",       f_dout,        32'd3);
      check_vec("f_cnt3",     f_cnt,         16'd3);
      check_vec("f_valid",    f_valid,       4'b0001);
      f_ack = 4'b0001; f_din = 32'd4;
      tick();
      check_vec("f_enwins",   f_valid,       4'b0001);
      check_vec("f_d4",       f_dout,        32'd4);
      check_vec("f_cnt4",     f_cnt,         16'd4);
      check_vec("f_noovr",    f_ovr,         4'b0000);
      f_en = '0;
      tick();
      check_vec("f_ack",      f_valid,       4'b0000);
      check_vec("f_hold",     f_dout,        32'd4);
      check_vec("f_cnt_hold", f_cnt,         16'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/capture_bank.md
Name: capture_bank

Overview:
- Parametrised, clocked successor to the team's single-bit level latch.
- Holds CHANNELS independent WIDTH-bit data registers, each gated by its own enable.
- Each channel runs a hold/valid/ack handshake and carries a sticky overrun flag; a free-running capture counter is shared across channels.
- Sits between asynchronous-source sample points (already synchronised upstream) and a polling consumer.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of independent channels (>=1).
- MODE, 1, 0 = FOLLOW (register tracks din while en high); 1 = CAPTURE (first enable captures and holds until ack).
- CNT_W, 16, width of the total-capture counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- din  input  CHANNELS*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- en  input  CHANNELS  per-channel load enable, sampled at clk.
- ack  input  CHANNELS  per-channel consumer acknowledge, sampled at clk.
- clr_ovr  input  1  clears all overrun flags.
- dout  output  CHANNELS*WIDTH  held data, same packing as din; registered.
- valid  output  CHANNELS  channel holds unacknowledged data.
- overrun  output  CHANNELS  sticky: a load was lost while the channel was held.
- cap_count  output  CNT_W  number of accepted loads across all channels.

Behaviour:
- Reset (async assert, released synchronously by the integrator): dout=0, valid=0, overrun=0, cap_count=0 immediately, independent of clk. Reset asserted mid-operation discards held data, and the asserting cycle produces no capture count.
- All outputs are registered; a load or ack takes effect at the clk edge where it is sampled (1-cycle latency to outputs).
- Per-channel state machine, state = valid: IDLE (valid=0), HELD (valid=1).
- MODE=1 (CAPTURE), per channel i:
  - IDLE & en: dout_i<=din_i, go HELD, counts as accepted load.
  - IDLE & ack: ignored; no error.
  - HELD & !en & !ack: hold; dout_i unchanged.
  - HELD & ack & !en: go IDLE; dout_i retains its last value.
  - HELD & ack & en: recapture (dout_i<=din_i), stay HELD, accepted load, no overrun.
  - HELD & en & !ack: data not loaded; overrun_i<=1; not counted.
- MODE=0 (FOLLOW), per channel i:
  - en: dout_i<=din_i every cycle en is high; valid_i<=1; each such cycle is an accepted load.
  - ack & !en: valid_i<=0. When ack and en coincide, en wins and valid stays 1.
  - overrun never sets in MODE=0 (tie-off behaviour; flags stay 0).
- Overrun flags: sticky until clr_ovr or reset. If clr_ovr and a new overrun event hit the same channel in the same cycle, set wins (flag ends at 1).
- cap_count:
  - Adds the number of accepted loads in the cycle (0..CHANNELS; simultaneous loads on several channels all count).
  - Modulo 2^CNT_W: wraps from all-ones past zero, no saturation, no flag.
  - Adder width must hold CHANNELS without truncation before the modulo.
- Channels are fully independent; activity on one never alters another's dout/valid/overrun.
- No combinational path from any input to any output.

Test Plan:
- Reset: assert reset mid-clock with channels HELD (dout=0xA5) -> dout, valid, overrun, cap_count all 0 before next clk edge; hold reset 3 cycles -> still 0.
- CAPTURE basic, MODE=1, ch0: en=1 din=0x3C for 1 cycle -> next edge dout0=0x3C, valid0=1, cap_count=1; din changes to 0xFF with en=0 -> dout0 stays 0x3C; ack=1 -> valid0=0, dout0=0x3C.
- Overrun: ch1 HELD with 0x11; en=1 din=0x22, ack=0 -> dout1=0x11, overrun1=1, cap_count unchanged; then clr_ovr coinciding with another en -> overrun1 remains 1; clr_ovr alone -> 0.
- Ack+en same cycle, ch2 HELD with 0x05: ack=1 en=1 din=0x06 -> dout2=0x06, valid2=1, overrun2=0, cap_count+1.
- Multi-channel count: CNT_W=4, preload cap_count to 14, en=4'b1111 on idle channels -> cap_count=2 (14+4 mod 16).
- FOLLOW, MODE=0: en held 3 cycles, din 1,2,3 -> dout tracks 1,2,3, cap_count+3; en=1 ack=1 -> valid stays 1; repeated en while valid -> overrun stays 0.
